quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 16, meaning the width of the signed position counter.
REQ-002 SHALL have parameter FILTER_CYCLES, default 4, meaning the number of consecutive stable cycles required to accept an input level (legal range 1..255).
REQ-003 SHALL have parameter SPEED_WINDOW, default 27000, meaning the speed measurement window in clk cycles (1 ms at 27 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports enc_a and enc_b, inputs, 1 bit each: raw quadrature encoder channels, asynchronous to clk.
REQ-007 SHALL have port clear, input, 1 bit: synchronous request to zero the position.
REQ-008 SHALL have port err_clear, input, 1 bit: synchronous request to clear the sticky error.
REQ-009 SHALL have port position, output, POS_WIDTH bits: signed two's-complement accumulated step count.
REQ-010 SHALL have port step_pulse, output, 1 bit: one-cycle strobe per accepted legal transition.
REQ-011 SHALL have port step_dir, output, 1 bit: direction of the last accepted step (1 = forward).
REQ-012 SHALL have port speed, output, 16 bits: signed net step count over the last completed window.
REQ-013 SHALL have port speed_valid, output, 1 bit: one-cycle strobe when speed updates.
REQ-014 SHALL have port error, output, 1 bit: sticky illegal-transition flag.

Function
REQ-015 SHALL pass each of enc_a and enc_b through a 2-flop synchronizer before any other use.
REQ-016 SHALL keep one filtered level and one stability counter per channel; the filtered level takes the synchronized value only after the synchronized value has differed from it for FILTER_CYCLES consecutive cycles, and any intermediate change restarts the count.
REQ-017 SHALL treat {a_f,b_f} as the state; forward = 00->01->11->10->00, reverse = the opposite order.
REQ-018 SHALL, on a forward transition, increment position by 1, pulse step_pulse, and set step_dir=1; on a reverse transition, decrement by 1, pulse step_pulse, and set step_dir=0.
REQ-019 SHALL, on a transition where both bits change in the same cycle, leave position, step_dir and step_pulse unchanged and set error.
REQ-020 SHALL have a fixed latency of FILTER_CYCLES+3 rising edges, counted from the first edge that samples a new, stable enc level to the edge that asserts step_pulse and updates position.
REQ-021 SHALL wrap position modulo 2^POS_WIDTH in both directions, with no saturation and no error.
REQ-022 SHALL, when clear is asserted, load position with 0 on the next edge; clear has priority over a same-cycle step, but step_pulse, step_dir and the speed accumulator still record that step.
REQ-023 SHALL run a window counter from 0 to SPEED_WINDOW-1; on the last cycle of each window, speed takes the accumulator value (including any step in that cycle), the accumulator restarts at 0, and speed_valid pulses for exactly one cycle.
REQ-024 SHALL saturate the 16-bit speed accumulator at +32767 and -32768.
REQ-025 SHALL hold error at 1 once set until err_clear is asserted; when an illegal transition and err_clear occur in the same cycle, error remains 1.
REQ-026 SHALL, on the first filtered state after reset, load that state without evaluating it as a transition, so that no step and no error result.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force position=0, step_pulse=0, step_dir=0, speed=0, speed_valid=0 and error=0.
REQ-028 SHALL, while rst_n=0, also clear the synchronizers, filters, window counter and accumulator, and re-arm the REQ-026 initial-load behaviour.
REQ-029 SHALL, when reset is asserted mid-window or mid-filter, discard all partial counts, and the first window after release SHALL be a full SPEED_WINDOW cycles.

Verification
REQ-030 Forward sequence of 8 legal steps, each held at least 10 cycles -> position=8, 8 step_pulses, step_dir=1, each step_pulse exactly FILTER_CYCLES+3 edges after the input change.
REQ-031 Glitch of 3 cycles on enc_a with FILTER_CYCLES=4 -> no step_pulse, position unchanged.
REQ-032 Reverse step from position=0 with POS_WIDTH=16 -> position=16'hFFFF; then 2 forward steps -> position=1.
REQ-033 enc 00->11 simultaneously -> error=1, position unchanged; err_clear pulse -> error=0; illegal transition coincident with err_clear -> error=1.
REQ-034 SPEED_WINDOW=100 with 5 forward and 2 reverse steps inside one window -> speed=3, and speed_valid high for exactly 1 cycle at window end.
REQ-035 Encoder held at 11 through reset release -> no step_pulse and no error; then 11->10 -> position=+1.

Source files
------------

// File: rtl/quad_decoder.sv
// ============================================================================
//  Module   : quad_decoder
//  Brief    : Filtered quadrature decoder with position, step strobe and
//             windowed speed measurement.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_decoder #(
  parameter int POS_WIDTH     = 16,
  parameter int FILTER_CYCLES = 4,
  parameter int SPEED_WINDOW  = 27000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 clear,
  input  logic                 err_clear,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_pulse,
  output logic                 step_dir,
  output logic signed [15:0]   speed,
  output logic                 speed_valid,
  output logic                 error
);

  localparam int         c_win_w    = (SPEED_WINDOW > 1) ? $clog2(SPEED_WINDOW) : 1;
  localparam logic [7:0] c_flt_last = 8'(FILTER_CYCLES - 1);

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_fvld;
  logic [1:0] r_sync_vld;

  assign w_raw = {enc_a, enc_b};

  // Synchronizer contents are meaningless until two edges after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync_vld <= 2'b00;
    else        r_sync_vld <= {r_sync_vld[0], 1'b1};
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic       r_s1;
      logic       r_s2;
      logic       r_filt;
      logic       r_vld;
      logic [7:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_filt <= 1'b0;
          r_vld  <= 1'b0;
          r_cnt  <= 8'd0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (!r_sync_vld[1]) begin
            r_cnt <= 8'd0;
          end else if (!r_vld) begin
            // Initial acquisition: track the input until it holds still.
            if (r_s2 != r_filt) begin
              r_filt <= r_s2;
              r_cnt  <= 8'd0;
            end else if (r_cnt == c_flt_last) begin
              r_vld <= 1'b1;
              r_cnt <= 8'd0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (r_s2 != r_filt) begin
            if (r_cnt == c_flt_last) begin
              r_filt <= r_s2;
              r_cnt  <= 8'd0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_cnt <= 8'd0;
          end
        end
      end

      assign w_filt[gi] = r_filt;
      assign w_fvld[gi] = r_vld;
    end
  endgenerate

  logic [1:0] r_prev;
  logic       r_primed;
  logic [1:0] w_cur_idx;
  logic [1:0] w_prev_idx;
  logic [1:0] w_diff;
  logic       w_eval;
  logic       w_fwd;
  logic       w_rev;
  logic       w_ill;

  // Gray-to-binary so forward motion is +1 mod 4.
  assign w_cur_idx  = {w_filt[1], w_filt[1] ^ w_filt[0]};
  assign w_prev_idx = {r_prev[1], r_prev[1] ^ r_prev[0]};
  assign w_diff     = w_cur_idx - w_prev_idx;
  assign w_eval     = r_primed && (w_filt != r_prev);
  assign w_fwd      = w_eval && (w_diff == 2'd1);
  assign w_rev      = w_eval && (w_diff == 2'd3);
  assign w_ill      = w_eval && (w_diff == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= 2'b00;
      r_primed <= 1'b0;
    end else if (&w_fvld) begin
      r_prev   <= w_filt;
      r_primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position   <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      error      <= 1'b0;
    end else begin
      step_pulse <= w_fwd | w_rev;
      if (w_fwd)      step_dir <= 1'b1;
      else if (w_rev) step_dir <= 1'b0;
      if (clear)      position <= '0;
      else if (w_fwd) position <= position + POS_WIDTH'(1);
      else if (w_rev) position <= position - POS_WIDTH'(1);
      if (w_ill)          error <= 1'b1;
      else if (err_clear) error <= 1'b0;
    end
  end

  logic [c_win_w-1:0] r_win;
  logic signed [15:0] r_acc;
  logic signed [15:0] w_acc_next;
  logic               w_win_last;

  assign w_win_last = (r_win == c_win_w'(SPEED_WINDOW - 1));

  always_comb begin
    w_acc_next = r_acc;
    if (w_fwd && (r_acc != 16'sh7FFF))      w_acc_next = r_acc + 16'sd1;
    else if (w_rev && (r_acc != 16'sh8000)) w_acc_next = r_acc - 16'sd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_acc       <= 16'sd0;
      speed       <= 16'sd0;
      speed_valid <= 1'b0;
    end else if (w_win_last) begin
      r_win       <= '0;
      r_acc       <= 16'sd0;
      speed       <= w_acc_next;
      speed_valid <= 1'b1;
    end else begin
      r_win       <= r_win + c_win_w'(1);
      r_acc       <= w_acc_next;
      speed_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
//  Module   : tb_quad_decoder
//  Brief    : Self-checking bench for quad_decoder (table vectors + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_decoder;

  localparam int POS_WIDTH     = 16;
  localparam int FILTER_CYCLES = 4;
  localparam int SPEED_WINDOW  = 100;
  localparam int LAT           = FILTER_CYCLES + 3;

  logic                 clk;
  logic                 rst_n;
  logic                 enc_a;
  logic                 enc_b;
  logic                 clear;
  logic                 err_clear;
  logic [POS_WIDTH-1:0] position;
  logic                 step_pulse;
  logic                 step_dir;
  logic signed [15:0]   speed;
  logic                 speed_valid;
  logic                 error;

  quad_decoder #(
    .POS_WIDTH    (POS_WIDTH),
    .FILTER_CYCLES(FILTER_CYCLES),
    .SPEED_WINDOW (SPEED_WINDOW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .clear      (clear),
    .err_clear  (err_clear),
    .position   (position),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .speed      (speed),
    .speed_valid(speed_valid),
    .error      (error)
  );

  typedef struct {
    logic [1:0]  ab;
    logic        step;
    logic        dir;
    logic [15:0] pos;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] pos;
    logic        dir;
    int          edg;
  } sb_t;

  sb_t  sbq[$];
  sb_t  sb_e;
  vec_t ta[8];
  vec_t tb[4];
  vec_t tc[7];
  vec_t td;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   c0;
  int   r0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Every observed step_pulse is matched against the oldest expected step.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && step_pulse === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_step", {31'd0, step_pulse}, 32'd0);
      end else begin
        sb_e = sbq.pop_front();
        chk("step_position", {16'd0, position}, {16'd0, sb_e.pos});
        chk("step_dir", {31'd0, step_dir}, {31'd0, sb_e.dir});
        chk("step_latency", cyc, sb_e.edg);
      end
    end
  end

  task automatic apply(input vec_t v, input string name);
    sb_t e;
    @(negedge clk);
    {enc_a, enc_b} = v.ab;
    if (v.step) begin
      e.pos = v.pos; e.dir = v.dir; e.edg = cyc + LAT;
      sbq.push_back(e);
    end
    repeat (10) @(negedge clk);
    chk({name, "_pos"}, {16'd0, position}, {16'd0, v.pos});
    chk({name, "_err"}, {31'd0, error}, {31'd0, v.err});
  endtask

  initial begin
    ta[0] = '{2'b01, 1, 1, 16'd1, 0};
    ta[1] = '{2'b11, 1, 1, 16'd2, 0};
    ta[2] = '{2'b10, 1, 1, 16'd3, 0};
    ta[3] = '{2'b00, 1, 1, 16'd4, 0};
    ta[4] = '{2'b01, 1, 1, 16'd5, 0};
    ta[5] = '{2'b11, 1, 1, 16'd6, 0};
    ta[6] = '{2'b10, 1, 1, 16'd7, 0};
    ta[7] = '{2'b00, 1, 1, 16'd8, 0};
    // Starting from state 01 at position 0.
    tb[0] = '{2'b00, 1, 0, 16'hFFFF, 0};
    tb[1] = '{2'b01, 1, 1, 16'h0000, 0};
    tb[2] = '{2'b11, 1, 1, 16'h0001, 0};
    tb[3] = '{2'b00, 0, 0, 16'h0001, 1};
    tc[0] = '{2'b01, 1, 1, 16'd1, 0};
    tc[1] = '{2'b11, 1, 1, 16'd2, 0};
    tc[2] = '{2'b10, 1, 1, 16'd3, 0};
    tc[3] = '{2'b00, 1, 1, 16'd4, 0};
    tc[4] = '{2'b01, 1, 1, 16'd5, 0};
    tc[5] = '{2'b00, 1, 0, 16'd4, 0};
    tc[6] = '{2'b10, 1, 0, 16'd3, 0};
    td    = '{2'b10, 1, 1, 16'd1, 0};

    rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; clear = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_position", {16'd0, position}, 32'd0);
    chk("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    for (int i = 0; i < 8; i++) apply(ta[i], "fwd");
    chk("fwd_dir", {31'd0, step_dir}, 32'd1);

    // Forward step with clear landing on the same edge: position must read 0.
    @(negedge clk);
    {enc_a, enc_b} = 2'b01;
    c0 = cyc;
    sbq.push_back('{16'd0, 1'b1, c0 + LAT});
    while (cyc < c0 + LAT - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("clear_pos", {16'd0, position}, 32'd0);

    for (int i = 0; i < 4; i++) apply(tb[i], "wrap");

    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    chk("err_clear", {31'd0, error}, 32'd0);

    // Illegal 00->11 evaluated on the same edge err_clear is high.
    @(negedge clk);
    {enc_a, enc_b} = 2'b11;
    c0 = cyc;
    while (cyc < c0 + LAT - 1) @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("err_vs_clear", {31'd0, error}, 32'd1);
    repeat (3) @(negedge clk);
    chk("illegal_pos", {16'd0, position}, 32'd1);

    // Three-cycle glitch on channel A, one short of the filter length.
    @(negedge clk); enc_a = 1'b0;
    repeat (3) @(negedge clk);
    enc_a = 1'b1;
    repeat (15) @(negedge clk);
    chk("glitch_pos", {16'd0, position}, 32'd1);

    // Asynchronous reset mid-window with non-zero state.
    chk("pre_rst_pending", sbq.size(), 32'd0);
    {enc_a, enc_b} = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_position", {16'd0, position}, 32'd0);
    chk("arst_dir", {31'd0, step_dir}, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    chk("arst_speed", {16'd0, speed}, 32'd0);
    chk("arst_speed_valid", {31'd0, speed_valid}, 32'd0);
    @(negedge clk);
    r0 = cyc;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 7; i++) apply(tc[i], "speed");
    while (cyc < r0 + SPEED_WINDOW - 1) @(negedge clk);
    chk("speed_valid_early", {31'd0, speed_valid}, 32'd0);
    @(negedge clk);
    chk("speed_valid_end", {31'd0, speed_valid}, 32'd1);
    chk("speed_value", {16'd0, speed}, 32'd3);
    @(negedge clk);
    chk("speed_valid_once", {31'd0, speed_valid}, 32'd0);

    // Encoder parked at 11 through reset release.
    {enc_a, enc_b} = 2'b11;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("park_pos", {16'd0, position}, 32'd0);
    chk("park_err", {31'd0, error}, 32'd0);
    apply(td, "park_step");

    repeat (5) @(negedge clk);
    chk("pending_steps", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
